// File: rtl/ifetch_unit_pkg.sv
// rtl/ifetch_unit_pkg.sv - shared types and defaults for the instruction fetch unit
package ifetch_unit_pkg;

   // Default widths of PC/memory addresses and of one instruction word
   localparam int ADDR_WIDTH_DEF = 32;
   localparam int INST_WIDTH_DEF = 32;

   // Fetch FSM: one state per byte read, plus idle and hand-off to decoder
   typedef enum logic [2:0] {
      IF_IDLE = 3'd0,
      IF_B0   = 3'd1,
      IF_B1   = 3'd2,
      IF_B2   = 3'd3,
      IF_B3   = 3'd4,
      IF_DONE = 3'd5
   } if_state_t;

   // Byte lane addressed in a byte-read state; zero in the other states
   function automatic logic [1:0] byte_sel(input if_state_t s);
      logic [1:0] k;
      k = 2'd0;
      case (s)
         IF_B1:   k = 2'd1;
         IF_B2:   k = 2'd2;
         IF_B3:   k = 2'd3;
         default: k = 2'd0;
      endcase
      return k;
   endfunction

   // True while the FSM is reading one of the four instruction bytes
   function automatic logic is_byte_state(input if_state_t s);
      return (s == IF_B0) || (s == IF_B1) || (s == IF_B2) || (s == IF_B3);
   endfunction

endpackage

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - fetches one 32-bit instruction as four little-endian byte reads
module ifetch_unit
   import ifetch_unit_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int INST_WIDTH = INST_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] pc_i,
   output logic                  pc_stall_o,
   output logic                  mem_req_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   input  logic                  mem_ack_i,
   input  logic [7:0]            mem_rdata_i,
   input  logic                  id_stall_i,
   output logic                  inst_valid_o,
   output logic [INST_WIDTH-1:0] inst_o,
   output logic [ADDR_WIDTH-1:0] inst_pc_o
);

   if_state_t             state;
   if_state_t             state_nxt;
   logic [ADDR_WIDTH-1:0] fetch_addr;
   logic [INST_WIDTH-1:0] inst_buf;
   logic [1:0]            lane;
   logic                  in_byte;

   assign lane    = byte_sel(state);
   assign in_byte = is_byte_state(state);

   // State register; reset abandons any fetch in progress
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IF_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state: advance one byte per ack, park in DONE until the decoder takes the word
   always_comb begin
      state_nxt = state;
      case (state)
         IF_IDLE: state_nxt = IF_B0;
         IF_B0:   if (mem_ack_i) state_nxt = IF_B1;
         IF_B1:   if (mem_ack_i) state_nxt = IF_B2;
         IF_B2:   if (mem_ack_i) state_nxt = IF_B3;
         IF_B3:   if (mem_ack_i) state_nxt = IF_DONE;
         IF_DONE: if (!id_stall_i) state_nxt = IF_IDLE;
         default: state_nxt = IF_IDLE;
      endcase
   end

   // Datapath: latch PC, collect bytes, publish the assembled word on the last ack
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_addr   <= '0;
         inst_buf     <= '0;
         inst_o       <= '0;
         inst_pc_o    <= '0;
         inst_valid_o <= 1'b0;
      end else begin
         case (state)
            IF_IDLE: begin
               fetch_addr <= pc_i;
            end
            IF_B0, IF_B1, IF_B2: begin
               if (mem_ack_i) begin
                  inst_buf[{lane, 3'b000} +: 8] <= mem_rdata_i;
               end
            end
            IF_B3: begin
               if (mem_ack_i) begin
                  inst_buf[INST_WIDTH-1 -: 8] <= mem_rdata_i;
                  inst_o       <= {mem_rdata_i, inst_buf[INST_WIDTH-9:0]};
                  inst_pc_o    <= fetch_addr;
                  inst_valid_o <= 1'b1;
               end
            end
            IF_DONE: begin
               if (!id_stall_i) begin
                  inst_valid_o <= 1'b0;
               end
            end
            default: begin
               inst_valid_o <= 1'b0;
            end
         endcase
      end
   end

   // Outputs: byte request/address while reading; PC released only on acceptance
   always_comb begin
      mem_req_o  = in_byte;
      mem_addr_o = '0;
      if (in_byte) begin
         mem_addr_o = fetch_addr + ADDR_WIDTH'(lane);
      end
      pc_stall_o = ~((state == IF_DONE) && !id_stall_i);
   end

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - directed self-checking bench for ifetch_unit
module tb_ifetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_i;
   logic        pc_stall_o;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_ack_i;
   logic [7:0]  mem_rdata_i;
   logic        id_stall_i;
   logic        inst_valid_o;
   logic [31:0] inst_o;
   logic [31:0] inst_pc_o;

   int   total = 0;
   int   bad = 0;
   int   wait_n = 0;
   logic force_ack = 1'b0;
   int   adv = 0;
   logic stall_s;

   ifetch_unit #(.ADDR_WIDTH(32), .INST_WIDTH(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .pc_i         (pc_i),
      .pc_stall_o   (pc_stall_o),
      .mem_req_o    (mem_req_o),
      .mem_addr_o   (mem_addr_o),
      .mem_ack_i    (mem_ack_i),
      .mem_rdata_i  (mem_rdata_i),
      .id_stall_i   (id_stall_i),
      .inst_valid_o (inst_valid_o),
      .inst_o       (inst_o),
      .inst_pc_o    (inst_pc_o)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] mem_byte(input logic [31:0] a);
      logic [7:0] d;
      case (a)
         32'h0000_0000: d = 8'h13;
         32'h0000_0001: d = 8'h05;
         32'h0000_0002: d = 8'h10;
         32'h0000_0003: d = 8'h00;
         32'h0000_0004: d = 8'h93;
         32'h0000_0005: d = 8'h00;
         32'h0000_0006: d = 8'h10;
         32'h0000_0007: d = 8'h00;
         32'hFFFF_FFFC: d = 8'hEF;
         32'hFFFF_FFFD: d = 8'hBE;
         32'hFFFF_FFFE: d = 8'hAD;
         32'hFFFF_FFFF: d = 8'hDE;
         default:       d = a[7:0] ^ 8'hA5;
      endcase
      return d;
   endfunction

   // Byte memory with wait_n wait cycles per read; force_ack injects a stray ack
   initial begin
      int waited;
      waited = 0;
      mem_ack_i = 1'b0;
      mem_rdata_i = 8'h00;
      forever begin
         @(negedge clk);
         if (force_ack) begin
            mem_ack_i = 1'b1;
            mem_rdata_i = mem_req_o ? mem_byte(mem_addr_o) : 8'hFF;
            waited = 0;
         end else if (mem_req_o) begin
            if (waited >= wait_n) begin
               mem_ack_i = 1'b1;
               mem_rdata_i = mem_byte(mem_addr_o);
               waited = 0;
            end else begin
               mem_ack_i = 1'b0;
               mem_rdata_i = 8'h5A;
               waited++;
            end
         end else begin
            mem_ack_i = 1'b0;
            mem_rdata_i = 8'h5A;
            waited = 0;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock; the PC register advances at the edge where pc_stall_o was low
   task automatic tick();
      @(negedge clk);
      stall_s = pc_stall_o;
      @(posedge clk);
      #1;
      if (!stall_s) begin
         pc_i = pc_i + 32'd4;
         adv++;
      end
   endtask

   initial begin
      int n;
      int adv0;
      logic seen;

      // ---- reset values, zero-wait fetch at PC 0 ----
      rst = 1'b1;
      pc_i = 32'h0;
      id_stall_i = 1'b0;
      wait_n = 0;
      tick();
      tick();
      chk("rst_valid", {31'b0, inst_valid_o}, 32'd0);
      chk("rst_req", {31'b0, mem_req_o}, 32'd0);
      chk("rst_addr", mem_addr_o, 32'd0);
      chk("rst_pcstall", {31'b0, pc_stall_o}, 32'd1);
      chk("rst_inst", inst_o, 32'd0);
      chk("rst_instpc", inst_pc_o, 32'd0);
      rst = 1'b0;
      for (int t = 1; t <= 4; t++) begin
         tick();
         chk($sformatf("zw_req%0d", t), {31'b0, mem_req_o}, 32'd1);
         chk($sformatf("zw_addr%0d", t), mem_addr_o, t - 1);
         chk($sformatf("zw_valid%0d", t), {31'b0, inst_valid_o}, 32'd0);
      end
      tick();
      chk("zw_valid5", {31'b0, inst_valid_o}, 32'd1);
      chk("zw_inst", inst_o, 32'h0010_0513);
      chk("zw_instpc", inst_pc_o, 32'd0);
      chk("zw_pcstall_done", {31'b0, pc_stall_o}, 32'd0);
      chk("zw_req_done", {31'b0, mem_req_o}, 32'd0);
      tick();
      chk("zw_valid_fall", {31'b0, inst_valid_o}, 32'd0);
      chk("zw_pcstall_idle", {31'b0, pc_stall_o}, 32'd1);

      // ---- two wait cycles per byte ----
      rst = 1'b1;
      pc_i = 32'h0;
      wait_n = 2;
      tick();
      tick();
      rst = 1'b0;
      for (int t = 1; t <= 12; t++) begin
         tick();
         chk($sformatf("w2_req%0d", t), {31'b0, mem_req_o}, 32'd1);
         chk($sformatf("w2_addr%0d", t), mem_addr_o, (t - 1) / 3);
      end
      tick();
      chk("w2_valid13", {31'b0, inst_valid_o}, 32'd1);
      chk("w2_inst", inst_o, 32'h0010_0513);
      chk("w2_instpc", inst_pc_o, 32'd0);
      n = 0;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         tick();
         n++;
         if (inst_valid_o) seen = 1'b1;
      end
      chk("w2_period", n, 32'd14);
      chk("w2_inst2", inst_o, 32'h0010_0093);
      chk("w2_instpc2", inst_pc_o, 32'd4);

      // ---- decoder stall held for five cycles in DONE ----
      id_stall_i = 1'b1;
      rst = 1'b1;
      pc_i = 32'h0;
      wait_n = 0;
      tick();
      tick();
      rst = 1'b0;
      repeat (5) tick();
      chk("st_valid", {31'b0, inst_valid_o}, 32'd1);
      adv0 = adv;
      for (int t = 1; t <= 5; t++) begin
         tick();
         chk($sformatf("st_hold_valid%0d", t), {31'b0, inst_valid_o}, 32'd1);
         chk($sformatf("st_hold_inst%0d", t), inst_o, 32'h0010_0513);
         chk($sformatf("st_hold_pcstall%0d", t), {31'b0, pc_stall_o}, 32'd1);
         chk($sformatf("st_hold_req%0d", t), {31'b0, mem_req_o}, 32'd0);
      end
      id_stall_i = 1'b0;
      #1;
      chk("st_release_pcstall", {31'b0, pc_stall_o}, 32'd0);
      tick();
      chk("st_idle_valid", {31'b0, inst_valid_o}, 32'd0);
      chk("st_idle_pcstall", {31'b0, pc_stall_o}, 32'd1);
      tick();
      chk("st_b0_req", {31'b0, mem_req_o}, 32'd1);
      chk("st_b0_addr", mem_addr_o, 32'd4);
      chk("st_one_adv", adv - adv0, 32'd1);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         tick();
         if (inst_valid_o) seen = 1'b1;
      end
      chk("st_second_seen", {31'b0, seen}, 32'd1);
      chk("st_inst2", inst_o, 32'h0010_0093);
      chk("st_instpc2", inst_pc_o, 32'd4);

      // ---- reset asserted mid-fetch in B2, stray ack after release ----
      rst = 1'b1;
      pc_i = 32'h0;
      tick();
      rst = 1'b0;
      tick();
      tick();
      tick();
      chk("rb_in_b2", mem_addr_o, 32'd2);
      rst = 1'b1;
      #1;
      chk("rb_req", {31'b0, mem_req_o}, 32'd0);
      chk("rb_addr", mem_addr_o, 32'd0);
      chk("rb_pcstall", {31'b0, pc_stall_o}, 32'd1);
      chk("rb_valid", {31'b0, inst_valid_o}, 32'd0);
      chk("rb_inst", inst_o, 32'd0);
      chk("rb_instpc", inst_pc_o, 32'd0);
      force_ack = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      force_ack = 1'b0;
      chk("rb_b0_req", {31'b0, mem_req_o}, 32'd1);
      chk("rb_b0_addr", mem_addr_o, 32'd0);
      repeat (4) tick();
      chk("rb_valid_after", {31'b0, inst_valid_o}, 32'd1);
      chk("rb_inst_after", inst_o, 32'h0010_0513);
      chk("rb_instpc_after", inst_pc_o, 32'd0);

      // ---- fetch at the top of the address space, then PC wrap ----
      rst = 1'b1;
      pc_i = 32'hFFFF_FFFC;
      tick();
      tick();
      rst = 1'b0;
      for (int t = 1; t <= 4; t++) begin
         tick();
         chk($sformatf("wr_addr%0d", t), mem_addr_o, 32'hFFFF_FFFC + (t - 1));
      end
      tick();
      chk("wr_valid", {31'b0, inst_valid_o}, 32'd1);
      chk("wr_inst", inst_o, 32'hDEAD_BEEF);
      chk("wr_instpc", inst_pc_o, 32'hFFFF_FFFC);
      tick();
      tick();
      chk("wr_next_req", {31'b0, mem_req_o}, 32'd1);
      chk("wr_next_addr", mem_addr_o, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch unit sitting between the program counter register and the decoder. Each instruction is fetched as four little-endian byte reads over the single-byte memory-controller port. The 32-bit word is then presented to the decoder with a valid/stall handshake. The block drives the PC stall line so the PC advances exactly once per instruction the decoder accepts.

## Interface
- ADDR_WIDTH, default `addrWidth (32): width of PC and memory addresses
- INST_WIDTH, default `instWidth (32): instruction width; fixed at 4 bytes

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- pc_i  in  ADDR_WIDTH  current PC from the PC register
- pc_stall_o  out  1  to staller/PC; 1 = hold PC, 0 = PC advances by 4 at this edge
- mem_req_o  out  1  byte read request to memory controller
- mem_addr_o  out  ADDR_WIDTH  byte address of request
- mem_ack_i  in  1  read done; mem_rdata_i valid this cycle
- mem_rdata_i  in  8  read byte
- id_stall_i  in  1  decoder cannot accept this cycle
- inst_valid_o  out  1  inst_o/inst_pc_o hold a complete instruction
- inst_o  out  INST_WIDTH  fetched instruction
- inst_pc_o  out  ADDR_WIDTH  address of inst_o

## Operation
- States: IDLE, B0, B1, B2, B3, DONE.
- IDLE:
  - fetch_addr <= pc_i; go to B0.
- Bk (k = 0..3):
  - mem_req_o = 1; mem_addr_o = fetch_addr + k, modulo 2^ADDR_WIDTH.
  - Request and address are held stable until mem_ack_i.
  - On ack: inst_buf[8k+7:8k] <= mem_rdata_i, then go to B(k+1).
  - From B3, go to DONE instead; on that edge inst_o <= assembled word, inst_pc_o <= fetch_addr, inst_valid_o <= 1.
- DONE:
  - mem_req_o = 0; inst_valid_o = 1.
  - If id_stall_i = 0, the instruction is accepted: inst_valid_o <= 0 and go to IDLE.
  - If id_stall_i = 1, hold every output unchanged.
- pc_stall_o = ~(state == DONE && !id_stall_i), combinational. The PC increments on the same edge the decoder accepts, and IDLE then latches the new PC.
- mem_ack_i is ignored outside B0..B3.
- mem_rdata_i is ignored when mem_ack_i = 0.
- mem_addr_o = 0 when mem_req_o = 0.
- Reset, including mid-fetch:
  - State goes to IDLE; fetch_addr, inst_buf, inst_o and inst_pc_o clear to 0.
  - inst_valid_o = 0, mem_req_o = 0, mem_addr_o = 0, pc_stall_o = 1.
  - Partially assembled bytes are discarded.
  - An ack arriving after reset release while in IDLE is ignored.

## Timing
- mem_ack_i may assert in the first cycle mem_req_o is high (zero-wait memory).
- Minimum instruction period is 6 cycles: IDLE, B0–B3, DONE.
- Each memory wait cycle adds one cycle.
- inst_valid_o rises the cycle after the B3 ack.
- inst_valid_o falls the cycle after acceptance.
- pc_stall_o is low for exactly one cycle per accepted instruction and never low outside DONE.
- id_stall_i held high keeps DONE indefinitely, with no memory traffic.

## Structure
- defines.v (shared) holds:
  - `addrWidth and `instWidth.
  - IF state encodings (`IF_IDLE … `IF_DONE, 3 bits).
- Single flat module:
  - One FSM always block with async reset.
  - One combinational block for mem_req_o, mem_addr_o and pc_stall_o.
  - No sub-module.

## Test plan
- Reset with a zero-wait memory returning 0x13,0x05,0x10,0x00 at PC 0:
  - Requests go to 0, 1, 2, 3.
  - inst_o = 0x00100513, inst_pc_o = 0.
  - inst_valid_o high at cycle 5 after reset release.
  - pc_stall_o low for one cycle in DONE.
- Memory with 2 wait cycles per byte:
  - mem_addr_o stays stable while mem_req_o is high.
  - Instruction period is 14 cycles.
  - Result matches the zero-wait case.
- id_stall_i high for 5 cycles in DONE:
  - inst_o and inst_valid_o held; pc_stall_o stays 1; no mem_req_o.
  - After release, exactly one PC advance, then fetch from PC 4.
- rst asserted while in B2:
  - All outputs return to their reset values immediately.
  - After release, fetch restarts at byte address 0.
  - The stale ack during IDLE is ignored.
- pc_i = 0xFFFFFFFC:
  - Requests go to 0xFFFFFFFC through 0xFFFFFFFF.
  - inst_pc_o = 0xFFFFFFFC.
  - Following fetch latches pc_i = 0x00000000 (PC wrap).
